pipo_arbiter: RTL and testbench
===============================

PIPO_ARBITER -- requirements
Module: pipo_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 4, register width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of registers in the bank (power of 2, AW = log2(DEPTH)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester request, held high until ack, then dropped (4-phase).
REQ-007 we  input  NREQ  per-requester write enable, 1 = write, 0 = read; sampled with req.
REQ-008 addr  input  NREQ*AW  per-requester register index, packed, requester i at [i*AW +: AW].
REQ-009 wdata  input  NREQ*W  per-requester write data, packed, requester i at [i*W +: W].
REQ-010 gnt  output  NREQ  one-hot grant, at most one bit high.
REQ-011 ack  output  1  one-cycle completion pulse to the granted requester.
REQ-012 rdata  output  W  read data, valid in the ack cycle and held until the next read completes.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 q  output  DEPTH*W  parallel contents of the whole bank, register j at [j*W +: W].

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, ACCESS and RELEASE.
REQ-016 IDLE: if any req bit is high, the block SHALL select a winner round-robin, set gnt, latch we/addr/wdata and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-017 Round-robin order SHALL start at (last_winner+1) mod NREQ; after reset last_winner = NREQ-1, so requester 0 has first priority.
REQ-018 GRANT: if the winner's req is still high, the FSM SHALL go to ACCESS; if it has dropped, the FSM SHALL abort to IDLE with no register access, gnt cleared and last_winner unchanged.
REQ-019 ACCESS, write: the bank register addr SHALL load the latched wdata at this edge, and q SHALL reflect it in the following cycle.
REQ-020 ACCESS, read: rdata SHALL load the bank register addr.
REQ-021 In ACCESS, ack SHALL pulse for exactly one cycle, last_winner SHALL update to the winner, and the FSM SHALL go to RELEASE.
REQ-022 RELEASE: the FSM SHALL hold gnt until the winner's req is low, then clear gnt and return to IDLE.
REQ-023 Minimum transaction length SHALL be 4 cycles from req to IDLE, which permits back-to-back grants to different requesters.
REQ-024 Requests from non-winners SHALL be ignored, but not lost, while busy.
REQ-025 Bank registers SHALL change only in an ACCESS write cycle.
REQ-026 Requests that arrive in the same cycle SHALL be resolved by round-robin only, with no fixed priority.

Reset
REQ-027 When rst is low, the block SHALL force state = IDLE, gnt = 0, ack = 0, busy = 0, rdata = 0, all bank registers = 0 (q = 0) and last_winner = NREQ-1.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction immediately, and no partial write SHALL survive.
REQ-029 After rst deasserts, the first request SHALL be sampled at the first rising clk edge.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, GRANT, ACCESS, RELEASE) and the default constants NREQ, W and DEPTH.
REQ-031 One sub-module, pipo_reg, SHALL be used: a W-bit parallel-in/parallel-out register with load enable and asynchronous active-low reset to 0, instantiated DEPTH times.
REQ-032 The round-robin select SHALL be a function inside pipo_arbiter, not a separate module.

Verification
REQ-033 Reset then a single write: req0=1, we0=1, addr0=2, wdata0=4'hA -> gnt=001 in GRANT, ack in ACCESS, q[11:8]=4'hA next cycle, other registers 0.
REQ-034 Read-back: after REQ-033, req1=1, we1=0, addr1=2 -> gnt=010, ack pulse, rdata=4'hA.
REQ-035 Simultaneous requests: req=111 all held, each dropped after its ack -> grant order 0,1,2, then 0 again if re-requested; gnt never multi-hot.
REQ-036 Abort: req2 raised for 1 cycle and dropped before GRANT completes -> no ack, q unchanged, next grant still starts search at the prior pointer.
REQ-037 Slow release: winner holds req 5 cycles after ack -> busy stays high and gnt held, with no second grant until req drops.
REQ-038 Reset mid-op: rst low during ACCESS of write wdata=4'hF -> q=0, gnt=0, ack=0, state IDLE; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/pipo_arbiter_pkg.sv
// Shared constants and FSM state encoding for the round-robin register-bank arbiter.
package pipo_arbiter_pkg;

  localparam int NREQ_DEF  = 3;
  localparam int W_DEF     = 4;
  localparam int DEPTH_DEF = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT   = ST_GRANT,
    ACCESS  = ST_ACCESS,
    RELEASE = ST_RELEASE
  } state_e;

endpackage

// File: rtl/pipo_reg.sv
// W-bit parallel-in/parallel-out register with load enable; loads on the clock edge
// when en_i is high, otherwise holds. Asynchronous clear to zero.
module pipo_reg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipo_arbiter.sv
// Round-robin arbiter granting NREQ 4-phase requesters single read/write access to a
// DEPTH x W register bank; a transaction takes at least 4 cycles, losers wait with req held.
module pipo_arbiter
  import pipo_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*W-1:0]  wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               ack_o,
  output logic [W-1:0]       rdata_o,
  output logic               busy_o,
  output logic [DEPTH*W-1:0] q_o
);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic [W-1:0]    bank_q [DEPTH];
  logic            bank_we;

  // Search starts one past the previous winner and wraps, so no requester has fixed priority.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          win_d        = rr_pick(req_i, last_q);
          gnt_d        = '0;
          gnt_d[win_d] = 1'b1;
          we_d         = we_i[win_d];
          addr_d       = addr_i[int'(win_d)*AW +: AW];
          wdata_d      = wdata_i[int'(win_d)*W +: W];
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // Read data is captured on entry to ACCESS so it is valid alongside ack.
        if (req_i[win_q]) begin
          state_d = ACCESS;
          if (!we_q) begin
            rdata_d = bank_q[addr_q];
          end
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      ACCESS: begin
        last_d  = win_q;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_i[win_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bank_we = (state_q == ACCESS) && we_q;

  for (genvar j = 0; j < DEPTH; j++) begin : g_bank
    pipo_reg #(.W(W)) u_reg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bank_we && (addr_q == AW'(j))),
      .d_i    (wdata_q),
      .q_o    (bank_q[j])
    );
    assign q_o[j*W +: W] = bank_q[j];
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = (state_q == ACCESS);
  assign busy_o  = (state_q != IDLE);
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_pipo_arbiter.sv
// Scoreboard bench: rounds of held requests are predicted in cyclic service order and checked by a negedge monitor.
module tb_pipo_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we;
  logic [5:0]  addr;
  logic [11:0] wdata;
  logic [2:0]  gnt;
  logic        ack, busy;
  logic [3:0]  rdata;
  logic [15:0] q;

  always #5 clk = ~clk;

  pipo_arbiter #(.NREQ(3), .W(4), .DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .gnt_o   (gnt),
    .ack_o   (ack),
    .rdata_o (rdata),
    .busy_o  (busy),
    .q_o     (q)
  );

  typedef struct {
    int       idx;
    bit       we;
    int       addr;
    logic [3:0] wd;
    logic [3:0] rd;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 0;
  bit         prev_ack = 0;
  bit         held[3];
  logic [15:0] q_exp;
  logic [3:0]  rd_exp;

  // Reference model: bank contents and the index of the last serviced requester.
  logic [3:0] m_bank[4];
  int         m_last;

  bit         t_we[3];
  int         t_addr[3];
  logic [3:0] t_wd[3];
  int         t_hold[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 4; a++) m_bank[a] = 4'h0;
    m_last = 2;
    q_exp  = 16'h0;
    rd_exp = 4'h0;
    sb.delete();
    for (int i = 0; i < 3; i++) held[i] = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("busy_vs_gnt", busy, |gnt);
      chk("q_bank", q, q_exp);
      for (int i = 0; i < 3; i++)
        if (held[i]) chk("held_gnt", gnt, 32'd1 << i);
      if (ack) begin
        chk("ack_single_cycle", prev_ack, 0);
        chk("ack_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("ack_gnt", gnt, 32'd1 << mon_e.idx);
          if (mon_e.we) q_exp[mon_e.addr*4 +: 4] = mon_e.wd;
          else rd_exp = mon_e.rd;
        end
      end
      chk("rdata", rdata, rd_exp);
      prev_ack = ack;
    end else begin
      prev_ack = 0;
    end
  end

  // All requesters in mask are raised together and held until served, so service follows cyclic order.
  task automatic do_round(input logic [2:0] mask);
    exp_t e;
    int   order[$];
    int   left[3];
    int   nack, last_it, exp_it, it, h;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (mask[i]) order.push_back(i);
    end
    foreach (order[k]) begin
      e.idx  = order[k];
      e.we   = t_we[order[k]];
      e.addr = t_addr[order[k]];
      e.wd   = t_wd[order[k]];
      e.rd   = m_bank[e.addr];
      if (e.we) m_bank[e.addr] = e.wd;
      sb.push_back(e);
    end
    m_last = order[order.size()-1];
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      left[i] = 0;
      if (mask[i]) begin
        req[i]           = 1'b1;
        we[i]            = t_we[i];
        addr[i*2 +: 2]   = t_addr[i][1:0];
        wdata[i*4 +: 4]  = t_wd[i];
      end
    end
    nack = 0;
    last_it = 0;
    for (it = 1; it <= 200 && !(req == 3'b000 && !busy); it++) begin
      @(negedge clk); #1;
      if (it == 1) chk("first_gnt", gnt, 32'd1 << order[0]);
      if (ack) begin
        if (nack == 0) exp_it = 2;
        else begin
          h = t_hold[order[nack-1]];
          exp_it = last_it + 4 + ((h > 0) ? h - 1 : 0);
        end
        if (nack < order.size()) chk("ack_cycle", it, exp_it);
        last_it = it;
        nack++;
        for (int i = 0; i < 3; i++)
          if (gnt[i] && req[i] && !held[i]) begin
            held[i] = 1;
            left[i] = t_hold[i];
          end
      end
      for (int i = 0; i < 3; i++)
        if (held[i]) begin
          if (left[i] == 0) begin
            req[i]  = 1'b0;
            held[i] = 0;
          end else left[i]--;
        end
    end
    chk("round_done", {req == 3'b000, busy}, 2'b10);
    chk("ack_count", nack, order.size());
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    model_reset();
    for (int i = 0; i < 3; i++) t_hold[i] = 0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_q", q, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;

    // Single write then read-back of the same register.
    t_we[0] = 1; t_addr[0] = 2; t_wd[0] = 4'hA;
    do_round(3'b001);
    chk("write_q", q, 16'h0A00);
    t_we[1] = 0; t_addr[1] = 2; t_wd[1] = 4'h3;
    do_round(3'b010);
    chk("readback", rdata, 4'hA);

    // Requester 2 drops its request during GRANT: no access, pointer kept.
    @(negedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[5:4] = 2'd0; wdata[11:8] = 4'h5;
    @(negedge clk);
    chk("abort_gnt", gnt, 3'b100);
    #1 req[2] = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, gnt}, 0);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        t_we[i] = 1'(i != 1); t_addr[i] = i + r; t_wd[i] = 4'(4 * r + i + 1);
        if (t_addr[i] > 3) t_addr[i] = 0;
      end
      do_round(3'b111);
    end

    // Slow release with a competitor waiting.
    t_we[0] = 1; t_addr[0] = 1; t_wd[0] = 4'hC; t_hold[0] = 5;
    t_we[1] = 0; t_addr[1] = 1; t_wd[1] = 4'h0; t_hold[1] = 0;
    do_round(3'b011);
    t_hold[0] = 0;

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 3; i++) begin
        t_we[i]   = 1'($urandom_range(0, 1));
        t_addr[i] = int'($urandom_range(0, 3));
        t_wd[i]   = 4'($urandom_range(0, 15));
        t_hold[i] = int'($urandom_range(0, 3));
      end
      do_round(3'($urandom_range(1, 7)));
    end

    // Reset during the ACCESS cycle of a write.
    mon_en = 0;
    @(negedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[3:2] = 2'd3; wdata[7:4] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("midop_ack", ack, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midop_q", q, 0);
    chk("midop_gnt", gnt, 0);
    chk("midop_ack_clr", ack, 0);
    chk("midop_busy", busy, 0);
    req = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midop_no_partial", q, 0);
    model_reset();
    mon_en = 1;
    for (int i = 0; i < 3; i++) begin
      t_we[i] = 0; t_addr[i] = 3; t_wd[i] = 4'h0; t_hold[i] = 0;
    end
    do_round(3'b111);
    mon_en = 0;
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
